// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR burst controller: command opcodes, FSM encoding
// and the one-step LFSR advance used by both the core and the output byte path.
package lfsr_pkg;

  localparam int LFSR_W_DEFAULT = 10;

  localparam logic [1:0] OP_SEED_LO   = 2'd0;
  localparam logic [1:0] OP_SEED_HI   = 2'd1;
  localparam logic [1:0] OP_SET_COUNT = 2'd2;
  localparam logic [1:0] OP_START     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_WAIT = 2'd2
  } fsm_state_e;

  // Fibonacci step on a right-aligned register of up to 16 bits; msb is W-1.
  // Callers truncate the result to their own width, so bits above msb are don't-care.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] s,
                                               input logic [3:0]  msb);
    logic fb;
    fb = s[msb] ^ s[msb - 4'd1];
    return (s << 1) | {15'd0, fb};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register: load has priority over step, otherwise the state holds.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int W = LFSR_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= W'(1);
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= W'(lfsr_advance(16'(state), 4'(W - 1)));
    end
  end

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer around lfsr_core: byte-wide command port in IDLE, one LFSR step
// per delivered output byte under valid/ready, sticky flag for an all-zero seed.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | accepting commands, cmd_ready = 1, no burst in progress
//   S_STEP | one cycle: advance LFSR, register output byte, decrement count
//   S_WAIT | out_valid held until out_ready; then next step or back to idle
module lfsr_burst_ctrl
  import lfsr_pkg::*;
#(
  parameter int W     = LFSR_W_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       lockup
);

  fsm_state_e fsm_q, fsm_d;

  logic [W-1:0]     seed_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] remaining_q;
  logic [W-1:0]     lfsr_state;
  logic [W-1:0]     load_val;
  logic             cmd_fire;
  logic             start_fire;
  logic             lfsr_load;
  logic             lfsr_step;

  assign cmd_ready  = (fsm_q == S_IDLE);
  assign busy       = (fsm_q != S_IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign start_fire = cmd_fire && (cmd_op == OP_START);

  // An all-zero seed would lock the LFSR forever, so substitute 1.
  assign lfsr_load  = start_fire && cmd_data[0];
  assign load_val   = (seed_q == '0) ? W'(1) : seed_q;
  assign lfsr_step  = (fsm_q == S_STEP);

  lfsr_core #(.W(W)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (load_val),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (start_fire) fsm_d = S_STEP;
      S_STEP:  fsm_d = S_WAIT;
      S_WAIT: begin
        if (out_ready) begin
          fsm_d = (remaining_q == '0) ? S_IDLE : S_STEP;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_q      <= W'(1);
      count_q     <= CNT_W'(1);
      remaining_q <= '0;
      lockup      <= 1'b0;
    end else if (cmd_fire) begin
      case (cmd_op)
        OP_SEED_LO:   seed_q[7:0]   <= cmd_data;
        OP_SEED_HI:   seed_q[W-1:8] <= cmd_data[W-9:0];
        OP_SET_COUNT: count_q       <= CNT_W'(cmd_data);
        default: begin
          remaining_q <= count_q;
          if (cmd_data[0]) begin
            lockup <= (seed_q == '0);
          end
        end
      endcase
    end else if (lfsr_step) begin
      // Wraps 0 -> all-ones, so a count of 0 yields 2^CNT_W bytes.
      remaining_q <= remaining_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'd0;
    end else if (lfsr_step) begin
      out_valid <= 1'b1;
      out_data  <= 8'(lfsr_advance(16'(lfsr_state), 4'(W - 1)));
    end else if (fsm_q == S_WAIT && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Self-checking bench for lfsr_burst_ctrl against a behavioural burst model.
module tb_lfsr_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       lockup;

  always #5 clk = ~clk;

  lfsr_burst_ctrl #(.W(10), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .lockup    (lockup)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cmd_timeouts = 0;

  int m_seed, m_count, m_state;
  bit m_lockup;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit collect_to;

  function automatic int model_next(input int s);
    return ((s * 2) & 'h3FF) | (((s >> 9) ^ (s >> 8)) & 1);
  endfunction

  task automatic model_reset();
    m_seed = 1; m_count = 1; m_state = 1; m_lockup = 0;
  endtask

  task automatic model_start(input bit reseed);
    int n;
    if (reseed) begin
      if (m_seed == 0) begin m_state = 1; m_lockup = 1; end
      else begin m_state = m_seed; m_lockup = 0; end
    end
    n = (m_count == 0) ? 256 : m_count;
    exp_q.delete();
    repeat (n) begin
      m_state = model_next(m_state);
      exp_q.push_back(8'(m_state & 'hFF));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    int i = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && i < 600) begin @(posedge clk); #1; i++; end
    if (i >= 600) cmd_timeouts++;
    else begin
      @(posedge clk); #1;
      case (op)
        2'd0: m_seed = (m_seed & 'h300) | int'(d);
        2'd1: m_seed = (m_seed & 'hFF) | ((int'(d) & 3) << 8);
        2'd2: m_count = int'(d);
        default: model_start(d[0]);
      endcase
    end
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int ready_pct);
    int cyc = 0;
    got_q.delete();
    collect_to = 0;
    while (got_q.size() < n) begin
      if (cyc > n * 40 + 50) begin collect_to = 1; break; end
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) got_q.push_back(out_data);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (lockup !== 1'b0) $display("FAIL reset_lockup: got %b want 0", lockup); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_short_burst();
    out_ready = 1'b1;
    send_cmd(2'd3, 8'h01);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL short_step_valid: got %b want 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL short_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h02) $display("FAIL short_byte: got %h want 02", out_data); else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL short_valid_drop: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL short_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL short_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_sequence();
    logic [7:0] table_q[$] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h01, 8'h03};
    send_cmd(2'd0, 8'h01); send_cmd(2'd1, 8'h00); send_cmd(2'd2, 8'd10); send_cmd(2'd3, 8'h01);
    collect(10, 100);
    n_checks++; if (collect_to) $display("FAIL seq_timeout: got %0d bytes want 10", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== table_q[i] || got_q[i] !== exp_q[i])
        $display("FAIL seq_byte%0d: got %h want %h", i, got_q[i], table_q[i]);
      else n_pass++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL seq_idle: busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_continue();
    send_cmd(2'd2, 8'd2); send_cmd(2'd3, 8'h00);
    collect(2, 100);
    n_checks++; if (got_q.size() !== 2) $display("FAIL cont_count: got %0d want 2", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL cont_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    int s3 = 1;
    bit stalled = 0;
    repeat (3) s3 = model_next(s3);
    send_cmd(2'd0, 8'h01); send_cmd(2'd1, 8'h00); send_cmd(2'd2, 8'd10); send_cmd(2'd3, 8'h01);
    got_q.delete();
    out_ready = 1'b1;
    while (got_q.size() < 10 && cyc < 200) begin
      if (out_valid && got_q.size() == 2 && !stalled) begin
        out_ready = 1'b0;
        repeat (5) begin
          n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h08)
            $display("FAIL bp_hold: got valid %b data %h want 1 08", out_valid, out_data); else n_pass++;
          n_checks++; if (dut.u_core.state !== 10'(s3))
            $display("FAIL bp_state: got %h want %h", dut.u_core.state, s3); else n_pass++;
          @(posedge clk); #1;
        end
        stalled = 1;
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++; if (got_q.size() !== 10) $display("FAIL bp_count: got %0d want 10", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lockup_wrap();
    int bad = 0;
    send_cmd(2'd0, 8'h00); send_cmd(2'd1, 8'h00); send_cmd(2'd2, 8'h00); send_cmd(2'd3, 8'h01);
    n_checks++; if (lockup !== 1'b1) $display("FAIL lock_set: got %b want 1", lockup); else n_pass++;
    collect(256, 70);
    n_checks++; if (collect_to || got_q.size() !== 256) $display("FAIL wrap_count: got %0d want 256", got_q.size()); else n_pass++;
    n_checks++; if (got_q.size() == 0 || got_q[0] !== 8'h02) $display("FAIL lock_first: got %h want 02", (got_q.size() > 0) ? got_q[0] : 8'hxx); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL wrap_bytes: got %0d wrong want 0", bad); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL wrap_end: valid %b busy %b want 0 0", out_valid, busy); else n_pass++;
    send_cmd(2'd0, 8'h05); send_cmd(2'd2, 8'd1); send_cmd(2'd3, 8'h01);
    n_checks++; if (lockup !== 1'b0) $display("FAIL lock_clear: got %b want 0", lockup); else n_pass++;
    collect(1, 100);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL lock_clear_byte: got %h want %h", (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); else n_pass++;
  endtask

  task automatic test_gating();
    send_cmd(2'd0, 8'h11); send_cmd(2'd2, 8'd3); send_cmd(2'd3, 8'h01);
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'hAA;
    repeat (4) begin
      n_checks++; if (cmd_ready !== 1'b0) $display("FAIL gate_ready: got %b want 0", cmd_ready); else n_pass++;
      @(posedge clk); #1;
    end
    cmd_op = 2'd2; cmd_data = 8'd7;
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n_checks++; if (dut.seed_q !== 10'(m_seed)) $display("FAIL gate_seed: got %h want %h", dut.seed_q, m_seed); else n_pass++;
    n_checks++; if (dut.count_q !== 8'(m_count)) $display("FAIL gate_count: got %0d want %0d", dut.count_q, m_count); else n_pass++;
    collect(3, 100);
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL gate_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int i = 0;
    send_cmd(2'd0, 8'h00); send_cmd(2'd1, 8'h00); send_cmd(2'd2, 8'd4); send_cmd(2'd3, 8'h01);
    out_ready = 1'b0;
    while (!out_valid && i < 20) begin @(posedge clk); #1; i++; end
    n_checks++; if (out_valid !== 1'b1 || lockup !== 1'b1) $display("FAIL mid_wait: valid %b lockup %b want 1 1", out_valid, lockup); else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) $display("FAIL mid_out: valid %b data %h want 0 00", out_valid, out_data); else n_pass++;
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || lockup !== 1'b0) $display("FAIL mid_ctrl: busy %b ready %b lockup %b want 0 1 0", busy, cmd_ready, lockup); else n_pass++;
    n_checks++; if (dut.seed_q !== 10'd1 || dut.count_q !== 8'd1 || dut.remaining_q !== 8'd0 || dut.u_core.state !== 10'd1)
      $display("FAIL mid_regs: seed %h count %h rem %h state %h want 1 1 0 1", dut.seed_q, dut.count_q, dut.remaining_q, dut.u_core.state); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    send_cmd(2'd3, 8'h01);
    collect(1, 100);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL mid_after: got %h want %h", (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] lo, hi, cnt, st;
      lo  = 8'($urandom_range(0, 255));
      hi  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin lo = 8'h00; hi = 8'hFC; end
      cnt = 8'($urandom_range(1, 16));
      st  = 8'($urandom_range(0, 255));
      send_cmd(2'd0, lo); send_cmd(2'd1, hi); send_cmd(2'd2, cnt); send_cmd(2'd3, st);
      n_checks++; if (lockup !== m_lockup) $display("FAIL rnd%0d_lockup: got %b want %b", it, lockup, m_lockup); else n_pass++;
      collect(exp_q.size(), 60);
      n_checks++; if (collect_to) $display("FAIL rnd%0d_timeout: got %0d want %0d", it, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rnd%0d_byte%0d: got %h want %h", it, i, got_q[i], exp_q[i]);
        else n_pass++;
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL rnd%0d_idle: busy %b want 0", it, busy); else n_pass++;
    end
    n_checks++; if (cmd_timeouts != 0) $display("FAIL cmd_accept: got %0d timeouts want 0", cmd_timeouts); else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short_burst();
    test_sequence();
    test_continue();
    test_backpressure();
    test_lockup_wrap();
    test_gating();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_burst_ctrl.md
# lfsr_burst_ctrl

Controller that sequences the 10-bit Fibonacci LFSR (feedback `state[W-1] ^ state[W-2]`) in counted bursts. It accepts byte-wide commands to load a seed and a burst length, then starts the burst. It steps the LFSR once per delivered output byte, under a valid/ready handshake. It sits between the pin-level command decoder (`ui_in`/`uio_in`) and the output byte bus (`uo_out`), and flags a stuck all-zero seed.

## Interface
Parameters:
- `W`, 10: LFSR width, legal range 9..16.
- `CNT_W`, 8: burst-length field width.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_op` in 2: opcode.
  - 0 = SEED_LO
  - 1 = SEED_HI
  - 2 = SET_COUNT
  - 3 = START
- `cmd_data` in 8: command payload.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready` at an edge.
- `out_valid` out 1: `out_data` holds an unconsumed LFSR byte.
- `out_data` out 8: `state[7:0]` after the step.
- `out_ready` in 1: consumer accepts the byte.
- `busy` out 1: burst in progress (FSM not IDLE).
- `lockup` out 1: sticky all-zero-seed flag.

## Operation
Commands are accepted only in IDLE, where `cmd_ready = 1`. In every other state `cmd_ready = 0` and commands wait.
- SEED_LO: `seed[7:0] <= cmd_data`.
- SEED_HI: `seed[W-1:8] <= cmd_data[W-9:0]`. Extra bits are ignored.
- SET_COUNT: `count <= cmd_data`. A value of 0 means 2^CNT_W steps (256).
- START with `cmd_data[0] = 1` (reseed): `state <= seed`.
  - If `seed == 0`: load `state <= 1` and set `lockup`.
  - Otherwise clear `lockup`.
- START with `cmd_data[0] = 0` (continue): `state` is unchanged and `lockup` is unchanged.
- On any accepted START: `remaining <= count`, then go to STEP.

FSM states and transitions:
- IDLE: waits for START.
- STEP: exactly one cycle.
  - `state <= {state[W-2:0], state[W-1] ^ state[W-2]}`.
  - `out_data <= next_state[7:0]`, `out_valid <= 1`.
  - `remaining <= remaining - 1`, computed modulo 2^CNT_W.
  - Go to WAIT.
- WAIT: hold `out_valid`, `out_data` and `state` stable until `out_ready`.
  - On the handshake edge: `out_valid <= 0`.
  - If `remaining == 0`, go to IDLE; otherwise go to STEP.
- Count 0 therefore yields 256 bytes, because the first decrement wraps 0 to 255.
- `out_ready` while `out_valid = 0` has no effect.
- `seed`, `count`, and `state` persist across bursts. Only reset or a command changes them.

## Timing
Reset values (all outputs and registers):
- FSM = IDLE, `cmd_ready = 1`, `busy = 0`, `lockup = 0`.
- `out_valid = 0`, `out_data = 0`.
- `seed = 1`, `count = 1`, `state = 1`, `remaining = 0`.

Latency and throughput:
- START accepted at edge k: STEP during cycle k..k+1, and `out_valid = 1` after edge k+1.
- Throughput is one byte per 2 cycles when `out_ready` is held high.
- After the final handshake edge, `busy = 0` and `cmd_ready = 1` from the next cycle.

Reset mid-burst:
- Reset returns everything to the reset values on the next edge.
- `out_valid` drops with no handshake, and the byte is lost.
- `cmd_ready`, `busy`, and `out_valid` are registered outputs or pure decodes of FSM state. There are no combinational paths from inputs.

## Structure
- `lfsr_pkg` holds:
  - opcode localparams `OP_SEED_LO`, `OP_SEED_HI`, `OP_SET_COUNT`, `OP_START`;
  - FSM state encoding (IDLE, STEP, WAIT);
  - default `W = 10`.
- Sub-module `lfsr_core` #(W) holds the state register and its controls.
  - Inputs: `load`, `load_val`, `step`.
  - Output: `state`.
  - Priority: `load` over `step`, and hold otherwise.
- The controller owns the FSM, the `seed`/`count`/`remaining` registers, the handshake, and `lockup`.

## Test plan
- **Reset defaults, short burst.** Reset, then START (`cmd_data = 1`) using the default `seed = 1` and `count = 1`, with `out_ready = 1`.
  - Required: one byte 0x02, `out_valid` first high 2 edges after reset release plus START, then `busy = 0`.
- **Sequence check.** SEED_LO 0x01, SEED_HI 0x00, SET_COUNT 10, START reseed, `out_ready = 1`.
  - Required bytes: 02 04 08 10 20 40 80 00 01 03, then IDLE.
- **Backpressure.** Same setup as the sequence check, with `out_ready` low for 5 cycles at byte 3.
  - Required: `out_data` holds 0x08, `state` is frozen, and no byte is dropped or duplicated.
- **Continue mode.** After the sequence check, SET_COUNT 2, then START with `cmd_data[0] = 0`.
  - Required bytes: 06, 0C, continuing from state 0x003.
- **Lockup and wrap-around.** SEED_LO 0, SEED_HI 0, SET_COUNT 0, START reseed.
  - Required: `lockup = 1`, the first byte is 0x02, and exactly 256 bytes are produced.
  - A later START with a nonzero seed clears `lockup`.
- **Command gating and mid-burst reset.**
  - Commands asserted while busy: `cmd_ready = 0`, and `seed`/`count` are unchanged.
  - Reset asserted in WAIT: all reset values appear on the next edge.
